demux4_reg: RTL

- Registered 1-to-4 demultiplexer; the distribution counterpart of the team's registered 4:1 mux (MUX4REG3).
- Steers one `bits`-wide input word to one of four output lanes (A, B, C, D) chosen by a 2-bit select.
- Each lane is a one-entry output register with a valid/ready handshake, so the four downstream consumers can stall independently.
- Sits between a single producer and four consumers in the datapath; per-lane delivery counters support debug and verification.

---
 rtl/demux4_reg.sv | 80 ++++++++
 1 files changed

// File: rtl/demux4_reg.sv
// Registered 1-to-4 demultiplexer. Each lane is a one-entry output register
// with its own valid/ready handshake and a delivery counter.
module demux4_reg #(
    parameter int bits     = 3,
    parameter int cnt_bits = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [bits-1:0]     in_data,
    input  logic                in_valid,
    input  logic [1:0]          select,
    output logic                in_ready,
    output logic [bits-1:0]     A,
    output logic [bits-1:0]     B,
    output logic [bits-1:0]     C,
    output logic [bits-1:0]     D,
    output logic                valid_A,
    output logic                valid_B,
    output logic                valid_C,
    output logic                valid_D,
    input  logic                ready_A,
    input  logic                ready_B,
    input  logic                ready_C,
    input  logic                ready_D,
    output logic [cnt_bits-1:0] count_A,
    output logic [cnt_bits-1:0] count_B,
    output logic [cnt_bits-1:0] count_C,
    output logic [cnt_bits-1:0] count_D
);

    logic [bits-1:0]     data_q [4];
    logic [cnt_bits-1:0] cnt_q  [4];
    logic [3:0]          valid_q;
    logic [3:0]          ready_v;
    logic                load;

    assign ready_v = {ready_D, ready_C, ready_B, ready_A};

    // Handshake: a word moves whenever valid and ready are both high at a
    // rising edge. in_ready looks only at the selected lane, never in_valid,
    // so a full lane that is draining this cycle can still be reloaded.
    assign in_ready = ~valid_q[select] | ready_v[select];
    assign load     = in_valid & in_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (valid_q[i] && ready_v[i]) begin
                    cnt_q[i]   <= cnt_q[i] + cnt_bits'(1);
                    valid_q[i] <= 1'b0;
                end
                // A load in the same cycle overrides the drain's valid clear.
                if (load && (select == i[1:0])) begin
                    data_q[i]  <= in_data;
                    valid_q[i] <= 1'b1;
                end
            end
        end
    end

    assign A       = data_q[0];
    assign B       = data_q[1];
    assign C       = data_q[2];
    assign D       = data_q[3];
    assign valid_A = valid_q[0];
    assign valid_B = valid_q[1];
    assign valid_C = valid_q[2];
    assign valid_D = valid_q[3];
    assign count_A = cnt_q[0];
    assign count_B = cnt_q[1];
    assign count_C = cnt_q[2];
    assign count_D = cnt_q[3];

endmodule
